// File: rtl/decode_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decode_queue_pkg
//  Brief    : Shared RV32I opcode / funct3 / funct7 constants and the
//             decoded operation-type encoding used by the decode queue.
//  Revision : 1.0 - initial release
// ============================================================================
package decode_queue_pkg;

  localparam int OPCODE_TYPE_WIDTH = 6;
  typedef logic [OPCODE_TYPE_WIDTH-1:0] optype_t;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // funct3 values
  localparam logic [2:0] F3_BEQ  = 3'b000, F3_BNE  = 3'b001, F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101, F3_BLTU = 3'b110, F3_BGEU = 3'b111;
  localparam logic [2:0] F3_LB   = 3'b000, F3_LH   = 3'b001, F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100, F3_LHU  = 3'b101;
  localparam logic [2:0] F3_SB   = 3'b000, F3_SH   = 3'b001, F3_SW   = 3'b010;
  localparam logic [2:0] F3_ADD  = 3'b000, F3_SLL  = 3'b001, F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011, F3_XOR  = 3'b100, F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110, F3_AND  = 3'b111;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Decoded operation types
  localparam optype_t OPTYPE_NOP   = 6'd0,  OPTYPE_LUI   = 6'd1,  OPTYPE_AUIPC = 6'd2;
  localparam optype_t OPTYPE_JAL   = 6'd3,  OPTYPE_JALR  = 6'd4,  OPTYPE_BEQ   = 6'd5;
  localparam optype_t OPTYPE_BNE   = 6'd6,  OPTYPE_BLT   = 6'd7,  OPTYPE_BGE   = 6'd8;
  localparam optype_t OPTYPE_BLTU  = 6'd9,  OPTYPE_BGEU  = 6'd10, OPTYPE_LB    = 6'd11;
  localparam optype_t OPTYPE_LH    = 6'd12, OPTYPE_LW    = 6'd13, OPTYPE_LBU   = 6'd14;
  localparam optype_t OPTYPE_LHU   = 6'd15, OPTYPE_SB    = 6'd16, OPTYPE_SH    = 6'd17;
  localparam optype_t OPTYPE_SW    = 6'd18, OPTYPE_ADDI  = 6'd19, OPTYPE_SLTI  = 6'd20;
  localparam optype_t OPTYPE_SLTIU = 6'd21, OPTYPE_XORI  = 6'd22, OPTYPE_ORI   = 6'd23;
  localparam optype_t OPTYPE_ANDI  = 6'd24, OPTYPE_SLLI  = 6'd25, OPTYPE_SRLI  = 6'd26;
  localparam optype_t OPTYPE_SRAI  = 6'd27, OPTYPE_ADD   = 6'd28, OPTYPE_SUB   = 6'd29;
  localparam optype_t OPTYPE_SLL   = 6'd30, OPTYPE_SLT   = 6'd31, OPTYPE_SLTU  = 6'd32;
  localparam optype_t OPTYPE_XOR   = 6'd33, OPTYPE_SRL   = 6'd34, OPTYPE_SRA   = 6'd35;
  localparam optype_t OPTYPE_OR    = 6'd36, OPTYPE_AND   = 6'd37, OPTYPE_FENCE = 6'd38;
  localparam optype_t OPTYPE_SYSTEM = 6'd39;

endpackage
`default_nettype wire

// File: rtl/rv32i_decode.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_decode
//  Brief    : Purely combinational RV32I decoder: operation type, register
//             fields, immediate, predicted next PC and illegal-encoding flag.
//  Revision : 1.0 - initial release
// ============================================================================
module rv32i_decode
  import decode_queue_pkg::*;
#(
  parameter int CHECK_ILLEGAL = 1
) (
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output optype_t     optype_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [31:0] imm_o,
  output logic [31:0] pred_target_o,
  output logic        is_ls_o,
  output logic        is_jump_o,
  output logic        illegal_o
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt;

  assign w_opcode = instr_i[6:0];
  assign w_funct3 = instr_i[14:12];
  assign w_funct7 = instr_i[31:25];
  assign w_imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign w_imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign w_imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign w_imm_u  = {instr_i[31:12], 12'b0};
  assign w_imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign w_shamt  = {27'b0, instr_i[24:20]};

  optype_t     w_raw_op;
  logic [31:0] w_imm;
  logic        w_no_rd, w_ls, w_jump, w_rel, w_bad, w_report;

  // Classify the word by opcode, then refine the operation by funct3/funct7
  always_comb begin
    w_raw_op = OPTYPE_NOP;
    w_imm    = 32'b0;
    w_no_rd  = 1'b0;
    w_ls     = 1'b0;
    w_jump   = 1'b0;
    w_rel    = 1'b0;
    w_bad    = (instr_i[1:0] != 2'b11);
    case (w_opcode)
      OPC_LUI:   begin w_raw_op = OPTYPE_LUI;   w_imm = w_imm_u; end
      OPC_AUIPC: begin w_raw_op = OPTYPE_AUIPC; w_imm = w_imm_u; end
      OPC_JAL:   begin w_raw_op = OPTYPE_JAL;   w_imm = w_imm_j; w_jump = 1'b1; w_rel = 1'b1; end
      OPC_JALR: begin
        w_raw_op = OPTYPE_JALR; w_imm = w_imm_i; w_jump = 1'b1;
        if (w_funct3 != 3'b000) w_bad = 1'b1;
      end
      OPC_BRANCH: begin
        w_imm = w_imm_b; w_no_rd = 1'b1; w_jump = 1'b1; w_rel = 1'b1;
        case (w_funct3)
          F3_BEQ:  w_raw_op = OPTYPE_BEQ;
          F3_BNE:  w_raw_op = OPTYPE_BNE;
          F3_BLT:  w_raw_op = OPTYPE_BLT;
          F3_BGE:  w_raw_op = OPTYPE_BGE;
          F3_BLTU: w_raw_op = OPTYPE_BLTU;
          F3_BGEU: w_raw_op = OPTYPE_BGEU;
          default: w_bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_imm = w_imm_i; w_ls = 1'b1;
        case (w_funct3)
          F3_LB:   w_raw_op = OPTYPE_LB;
          F3_LH:   w_raw_op = OPTYPE_LH;
          F3_LW:   w_raw_op = OPTYPE_LW;
          F3_LBU:  w_raw_op = OPTYPE_LBU;
          F3_LHU:  w_raw_op = OPTYPE_LHU;
          default: w_bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        w_imm = w_imm_s; w_no_rd = 1'b1; w_ls = 1'b1;
        case (w_funct3)
          F3_SB:   w_raw_op = OPTYPE_SB;
          F3_SH:   w_raw_op = OPTYPE_SH;
          F3_SW:   w_raw_op = OPTYPE_SW;
          default: w_bad = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        w_imm = w_imm_i;
        case (w_funct3)
          F3_ADD:  w_raw_op = OPTYPE_ADDI;
          F3_SLT:  w_raw_op = OPTYPE_SLTI;
          F3_SLTU: w_raw_op = OPTYPE_SLTIU;
          F3_XOR:  w_raw_op = OPTYPE_XORI;
          F3_OR:   w_raw_op = OPTYPE_ORI;
          F3_AND:  w_raw_op = OPTYPE_ANDI;
          F3_SLL: begin
            w_raw_op = OPTYPE_SLLI; w_imm = w_shamt;
            if (w_funct7 != F7_BASE) w_bad = 1'b1;
          end
          default: begin
            // funct3 101: shift right, logical or arithmetic by funct7
            w_raw_op = (w_funct7 == F7_ALT) ? OPTYPE_SRAI : OPTYPE_SRLI;
            w_imm    = w_shamt;
            if (w_funct7 != F7_BASE && w_funct7 != F7_ALT) w_bad = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        if (w_funct7 == F7_ALT) begin
          case (w_funct3)
            F3_ADD:  w_raw_op = OPTYPE_SUB;
            F3_SRL:  w_raw_op = OPTYPE_SRA;
            default: w_bad = 1'b1;
          endcase
        end else if (w_funct7 == F7_BASE) begin
          case (w_funct3)
            F3_ADD:  w_raw_op = OPTYPE_ADD;
            F3_SLL:  w_raw_op = OPTYPE_SLL;
            F3_SLT:  w_raw_op = OPTYPE_SLT;
            F3_SLTU: w_raw_op = OPTYPE_SLTU;
            F3_XOR:  w_raw_op = OPTYPE_XOR;
            F3_SRL:  w_raw_op = OPTYPE_SRL;
            F3_OR:   w_raw_op = OPTYPE_OR;
            default: w_raw_op = OPTYPE_AND;
          endcase
        end else begin
          w_bad = 1'b1;
        end
      end
      OPC_FENCE:  begin w_raw_op = OPTYPE_FENCE;  w_imm = w_imm_i; end
      OPC_SYSTEM: begin w_raw_op = OPTYPE_SYSTEM; w_imm = w_imm_i; end
      default:    w_bad = 1'b1;
    endcase
  end

  // An illegal word is neutralised into a NOP so dispatch never acts on it
  assign w_report      = (CHECK_ILLEGAL != 0) && w_bad;
  assign optype_o      = w_report ? OPTYPE_NOP : w_raw_op;
  assign rd_o          = (w_report || w_no_rd) ? 5'd0 : instr_i[11:7];
  assign rs1_o         = instr_i[19:15];
  assign rs2_o         = instr_i[24:20];
  assign imm_o         = w_imm;
  assign is_ls_o       = w_ls && !w_report;
  assign is_jump_o     = w_jump && !w_report;
  assign illegal_o     = w_report;
  assign pred_target_o = (w_rel && !w_report) ? (pc_i + w_imm) : (pc_i + 32'd4);

endmodule
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : decode_queue
//  Brief    : Circular instruction queue between fetch and dispatch; the head
//             entry is decoded combinationally for dispatch.
//  Revision : 1.0 - initial release
// ============================================================================
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH_LOG     = 3,
  parameter int CHECK_ILLEGAL = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  input  logic                 if_valid,
  input  logic [31:0]          if_instr,
  input  logic [31:0]          if_pc,
  output logic                 if_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output optype_t              out_optype,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [31:0]          out_imm,
  output logic [31:0]          out_pred_target,
  output logic                 out_is_ls,
  output logic                 out_is_jump,
  output logic                 out_illegal,
  output logic [DEPTH_LOG:0]   count
);

  localparam int               DEPTH  = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] C_FULL = {1'b1, {DEPTH_LOG{1'b0}}};

  logic [31:0]          instr_mem_q [DEPTH];
  logic [31:0]          pc_mem_q    [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic                 w_push, w_pop;

  // if_ready ignores pops so a full queue never passes data straight through
  assign if_ready  = (count_q != C_FULL);
  assign out_valid = (count_q != '0) && rdy_in;
  assign w_push    = if_valid && if_ready && rdy_in && !flush;
  assign w_pop     = out_valid && out_ready && !flush;
  assign count     = count_q;

  // Next pointer / occupancy; flush wins over any push or pop while enabled
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rdy_in) begin
      if (flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end else begin
        if (w_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG'(1);
        if (w_push && !w_pop)      count_d = count_q + (DEPTH_LOG+1)'(1);
        else if (w_pop && !w_push) count_d = count_q - (DEPTH_LOG+1)'(1);
      end
    end
  end

  // Pointer and occupancy registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because count gates visibility
  always_ff @(posedge clk_in) begin
    if (w_push && !rst_in) begin
      instr_mem_q[wr_ptr_q] <= if_instr;
      pc_mem_q[wr_ptr_q]    <= if_pc;
    end
  end

  assign out_pc = pc_mem_q[rd_ptr_q];

  rv32i_decode #(
    .CHECK_ILLEGAL (CHECK_ILLEGAL)
  ) u_decode (
    .instr_i       (instr_mem_q[rd_ptr_q]),
    .pc_i          (pc_mem_q[rd_ptr_q]),
    .optype_o      (out_optype),
    .rd_o          (out_rd),
    .rs1_o         (out_rs1),
    .rs2_o         (out_rs2),
    .imm_o         (out_imm),
    .pred_target_o (out_pred_target),
    .is_ls_o       (out_is_ls),
    .is_jump_o     (out_is_jump),
    .illegal_o     (out_illegal)
  );

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_queue
//  Brief    : Self-checking bench for decode_queue (DEPTH_LOG=3), with a
//             second instance built with CHECK_ILLEGAL=0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1, rdy_in = 1'b1, flush = 1'b0;
  logic        if_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] if_instr = 32'b0, if_pc = 32'b0;

  logic        if_ready, out_valid, out_is_ls, out_is_jump, out_illegal;
  logic [31:0] out_pc, out_imm, out_pred_target;
  optype_t     out_optype;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [3:0]  count;

  logic        nc_if_ready, nc_out_valid, nc_is_ls, nc_is_jump, nc_illegal;
  logic [31:0] nc_pc, nc_imm, nc_tgt;
  optype_t     nc_optype;
  logic [4:0]  nc_rd, nc_rs1, nc_rs2;
  logic [3:0]  nc_count;

  decode_queue #(.DEPTH_LOG(3), .CHECK_ILLEGAL(1)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_optype(out_optype), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_pred_target(out_pred_target), .out_is_ls(out_is_ls),
    .out_is_jump(out_is_jump), .out_illegal(out_illegal), .count(count));

  decode_queue #(.DEPTH_LOG(3), .CHECK_ILLEGAL(0)) dut_nc (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(nc_if_ready),
    .out_valid(nc_out_valid), .out_ready(out_ready), .out_pc(nc_pc),
    .out_optype(nc_optype), .out_rd(nc_rd), .out_rs1(nc_rs1), .out_rs2(nc_rs2),
    .out_imm(nc_imm), .out_pred_target(nc_tgt), .out_is_ls(nc_is_ls),
    .out_is_jump(nc_is_jump), .out_illegal(nc_illegal), .count(nc_count));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct packed {
    optype_t op; logic [4:0] rd, rs1, rs2; logic [31:0] imm, tgt; logic ls, jmp, ill;
  } dec_t;

  ent_t mq[$];
  bit   started = 1'b0;

  // Table-driven RV32I decode straight from the ISA encoding rules
  function automatic dec_t mdec(input logic [31:0] w, input logic [31:0] pc);
    optype_t lops[8] = '{OPTYPE_LB, OPTYPE_LH, OPTYPE_LW, OPTYPE_NOP, OPTYPE_LBU, OPTYPE_LHU, OPTYPE_NOP, OPTYPE_NOP};
    optype_t sops[8] = '{OPTYPE_SB, OPTYPE_SH, OPTYPE_SW, OPTYPE_NOP, OPTYPE_NOP, OPTYPE_NOP, OPTYPE_NOP, OPTYPE_NOP};
    optype_t bops[8] = '{OPTYPE_BEQ, OPTYPE_BNE, OPTYPE_NOP, OPTYPE_NOP, OPTYPE_BLT, OPTYPE_BGE, OPTYPE_BLTU, OPTYPE_BGEU};
    optype_t iops[8] = '{OPTYPE_ADDI, OPTYPE_SLLI, OPTYPE_SLTI, OPTYPE_SLTIU, OPTYPE_XORI, OPTYPE_SRLI, OPTYPE_ORI, OPTYPE_ANDI};
    optype_t rops[8] = '{OPTYPE_ADD, OPTYPE_SLL, OPTYPE_SLT, OPTYPE_SLTU, OPTYPE_XOR, OPTYPE_SRL, OPTYPE_OR, OPTYPE_AND};
    logic [7:0] lok = 8'b0011_0111, sok = 8'b0000_0111, bok = 8'b1111_0011;
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    logic [31:0] immI = 32'($signed(w[31:20]));
    logic [31:0] immS = 32'($signed({w[31:25], w[11:7]}));
    logic [31:0] immB = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
    logic [31:0] immJ = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
    logic rel = 1'b0;
    dec_t d;
    d.op = OPTYPE_NOP; d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
    d.imm = 32'd0; d.ls = 1'b0; d.jmp = 1'b0; d.ill = (w[1:0] != 2'b11);
    case (w[6:0])
      7'h37: begin d.op = OPTYPE_LUI;   d.imm = {w[31:12], 12'h000}; end
      7'h17: begin d.op = OPTYPE_AUIPC; d.imm = {w[31:12], 12'h000}; end
      7'h6F: begin d.op = OPTYPE_JAL;   d.imm = immJ; d.jmp = 1'b1; rel = 1'b1; end
      7'h67: begin d.op = OPTYPE_JALR;  d.imm = immI; d.jmp = 1'b1; if (f3 != 0) d.ill = 1'b1; end
      7'h63: begin d.op = bops[f3]; d.imm = immB; d.rd = 0; d.jmp = 1'b1; rel = 1'b1; if (!bok[f3]) d.ill = 1'b1; end
      7'h03: begin d.op = lops[f3]; d.imm = immI; d.ls = 1'b1; if (!lok[f3]) d.ill = 1'b1; end
      7'h23: begin d.op = sops[f3]; d.imm = immS; d.rd = 0; d.ls = 1'b1; if (!sok[f3]) d.ill = 1'b1; end
      7'h13: begin
        d.op = iops[f3]; d.imm = immI;
        if (f3 == 3'd1 || f3 == 3'd5) d.imm = {27'd0, w[24:20]};
        if (f3 == 3'd1 && f7 != 0) d.ill = 1'b1;
        if (f3 == 3'd5 && f7 == 7'h20) d.op = OPTYPE_SRAI;
        if (f3 == 3'd5 && f7 != 0 && f7 != 7'h20) d.ill = 1'b1;
      end
      7'h33: begin
        if (f7 == 0) d.op = rops[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) d.op = OPTYPE_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) d.op = OPTYPE_SRA;
        else d.ill = 1'b1;
      end
      7'h0F: begin d.op = OPTYPE_FENCE;  d.imm = immI; end
      7'h73: begin d.op = OPTYPE_SYSTEM; d.imm = immI; end
      default: d.ill = 1'b1;
    endcase
    if (d.ill) begin d.op = OPTYPE_NOP; d.rd = 0; d.ls = 1'b0; d.jmp = 1'b0; rel = 1'b0; end
    d.tgt = rel ? pc + d.imm : pc + 32'd4;
    return d;
  endfunction

  // Queue model: reset > freeze > flush > (pop, push); a full queue rejects push
  always @(posedge clk) begin
    started <= 1'b1;
    if (rst_in) mq.delete();
    else if (rdy_in) begin
      if (flush) mq.delete();
      else if (if_valid && mq.size() != DEPTH) begin
        if (mq.size() != 0 && out_ready) void'(mq.pop_front());
        mq.push_back('{instr: if_instr, pc: if_pc});
      end else if (mq.size() != 0 && out_ready) void'(mq.pop_front());
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (started) begin
      dec_t d;
      logic exp_v;
      exp_v = (mq.size() != 0) && rdy_in;
      chk("count", 32'(count), 32'(mq.size()));
      chk("nc_count", 32'(nc_count), 32'(mq.size()));
      chk("if_ready", 32'(if_ready), 32'(mq.size() != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) begin
        d = mdec(mq[0].instr, mq[0].pc);
        chk("out_pc", out_pc, mq[0].pc);
        chk("optype", 32'(out_optype), 32'(d.op));
        chk("rd", 32'(out_rd), 32'(d.rd));
        chk("rs1", 32'(out_rs1), 32'(d.rs1));
        chk("rs2", 32'(out_rs2), 32'(d.rs2));
        chk("imm", out_imm, d.imm);
        chk("pred_target", out_pred_target, d.tgt);
        chk("is_ls", 32'(out_is_ls), 32'(d.ls));
        chk("is_jump", 32'(out_is_jump), 32'(d.jmp));
        chk("illegal", 32'(out_illegal), 32'(d.ill));
        chk("nc_illegal", 32'(nc_illegal), 32'd0);
        if (!d.ill) begin
          chk("nc_pc", nc_pc, mq[0].pc);
          chk("nc_optype", 32'(nc_optype), 32'(d.op));
          chk("nc_rd_rs", {17'd0, nc_rd, nc_rs1, nc_rs2}, {17'd0, d.rd, d.rs1, d.rs2});
          chk("nc_imm", nc_imm, d.imm);
          chk("nc_tgt", nc_tgt, d.tgt);
          chk("nc_flags", {30'd0, nc_is_ls, nc_is_jump}, {30'd0, d.ls, d.jmp});
          chk("nc_valid", 32'(nc_out_valid), 32'd1);
          chk("nc_ready", 32'(nc_if_ready), 32'(if_ready));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] w, input logic [31:0] pc);
    if_valid = 1'b1; if_instr = w; if_pc = pc;
    step();
    if_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 20 && mq.size() != 0; k++) step();
    out_ready = 1'b0;
    chk("drain_empty", 32'(count), 32'd0);
  endtask

  function automatic logic [31:0] gen(input int i);
    logic [4:0] r;
    r = 5'(i);
    case (i % 5)
      0: return {12'(i), 5'd1, 3'b000, r, 7'b0010011};
      1: return 32'hFE000EE3;
      2: return {7'd0, r, 5'd2, 3'b010, 5'd8, 7'b0100011};
      3: return {17'd0, 3'b110, r, 7'b0000011};
      default: return {7'd0, r, 5'd3, 3'b001, 5'd3, 7'b0010011};
    endcase
  endfunction

  logic [31:0] words [8] = '{32'h123450B7, 32'h00001117, 32'h008001EF, 32'h00410267,
                             32'h00512423, 32'hFFC12303, 32'h40208433, 32'h4030D493};

  initial begin
    dec_t pin;
    int pushed, popped, frz;
    logic acc, pp;

    // model pins against hand-decoded words
    pin = mdec(32'hFE000EE3, 32'h200);
    chk("model_beq_imm", pin.imm, 32'hFFFFFFFC);
    chk("model_beq_tgt", pin.tgt, 32'h000001FC);
    pin = mdec(32'h00003003, 32'h300);
    chk("model_ld_ill", 32'(pin.ill), 32'd1);

    step(); step();
    rst_in = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);

    // addi x1,x0,5 at 0x100
    push1(32'h00500093, 32'h100);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_op", 32'(out_optype), 32'(OPTYPE_ADDI));
    chk("addi_rd", 32'(out_rd), 32'd1);
    chk("addi_rs1", 32'(out_rs1), 32'd0);
    chk("addi_imm", out_imm, 32'd5);
    chk("addi_tgt", out_pred_target, 32'h104);
    drain();

    // beq x0,x0,-4 at 0x200
    push1(32'hFE000EE3, 32'h200);
    chk("beq_op", 32'(out_optype), 32'(OPTYPE_BEQ));
    chk("beq_rd", 32'(out_rd), 32'd0);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_jump", 32'(out_is_jump), 32'd1);
    chk("beq_tgt", out_pred_target, 32'h1FC);
    drain();

    // illegal load funct3 011, second one with rd field x1
    push1(32'h00003003, 32'h300);
    push1(32'h00003083, 32'h304);
    chk("ld_illegal", 32'(out_illegal), 32'd1);
    chk("ld_op", 32'(out_optype), 32'(OPTYPE_NOP));
    chk("ld_nc_legal", 32'(nc_illegal), 32'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("ld2_illegal", 32'(out_illegal), 32'd1);
    chk("ld2_rd", 32'(out_rd), 32'd0);
    chk("ld2_is_ls", 32'(out_is_ls), 32'd0);
    drain();

    // fill to full, reject 9th, then push+pop while full
    for (int i = 0; i < 8; i++) push1(words[i], 32'h400 + 32'(4 * i));
    chk("full_count", 32'(count), 32'd8);
    chk("full_if_ready", 32'(if_ready), 32'd0);
    push1(32'h00100093, 32'h500);
    chk("reject_count", 32'(count), 32'd8);
    if_valid = 1'b1; out_ready = 1'b1; if_instr = 32'h00200093; if_pc = 32'h504;
    step();
    if_valid = 1'b0; out_ready = 1'b0;
    chk("full_pushpop_count", 32'(count), 32'd7);
    chk("full_pushpop_head", out_pc, 32'h404);
    drain();

    // flush with a queue of 5 while push and pop are both requested
    for (int i = 0; i < 5; i++) push1(words[i], 32'h600 + 32'(4 * i));
    flush = 1'b1; if_valid = 1'b1; out_ready = 1'b1; if_instr = 32'h00500093; if_pc = 32'h700;
    step();
    flush = 1'b0; if_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    step();
    chk("flush_nothing", 32'(count), 32'd0);

    // reset overrides a concurrent push
    push1(words[0], 32'h800);
    push1(words[1], 32'h804);
    rst_in = 1'b1; if_valid = 1'b1; out_ready = 1'b1;
    step();
    rst_in = 1'b0; if_valid = 1'b0; out_ready = 1'b0;
    chk("rst2_count", 32'(count), 32'd0);
    chk("rst2_if_ready", 32'(if_ready), 32'd1);

    // streaming 20 entries with random dispatch and a 3-cycle freeze
    pushed = 0; popped = 0; frz = 0;
    for (int cyc = 0; cyc < 400 && popped < 20; cyc++) begin
      rdy_in    = !(cyc >= 8 && cyc < 11);
      flush     = (cyc == 9);
      if_valid  = (pushed < 20);
      if_instr  = gen(pushed);
      if_pc     = 32'h1000 + 32'(4 * pushed);
      out_ready = 1'($urandom_range(0, 1));
      frz       = mq.size();
      acc = if_valid && rdy_in && (mq.size() != DEPTH);
      pp  = rdy_in && out_ready && (mq.size() != 0);
      step();
      if (!rdy_in) begin
        chk("freeze_count", 32'(count), 32'(frz));
        chk("freeze_valid", 32'(out_valid), 32'd0);
      end
      pushed += int'(acc);
      popped += int'(pp);
    end
    rdy_in = 1'b1; flush = 1'b0; if_valid = 1'b0; out_ready = 1'b0;
    chk("stream_popped", 32'(popped), 32'd20);
    chk("stream_count", 32'(count), 32'd0);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
